sudoku_uart_rx: RTL
===================

Name: sudoku_uart_rx

Overview:
Serial receive front end for the sudoku accelerator. It consumes the chip-level ser_rx pad input and deserialises 8N1 UART frames. Received bytes are buffered in a small FIFO and presented on a valid/ready stream to the accelerator's command/puzzle loader. It also reports framing and overrun events so the accelerator can raise user_irq.

Parameters:
FIFO_DEPTH, 4, number of buffered bytes; power of two, at least 2
DIV_WIDTH, 16, width of the clk_div input

Ports:
wb_clk_i  input  1  system clock; only clock in the block
wb_rst_i  input  1  synchronous, active-high reset
enable  input  1  receiver enable; 0 forces FSM to IDLE, FIFO contents retained
clk_div  input  DIV_WIDTH  cycles per bit minus 1; legal range 7 or more
ser_rx  input  1  asynchronous serial line, idle high
rx_data  output  8  FIFO head byte
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer accepts head byte
frame_err  output  1  one-cycle pulse when the stop bit samples 0
overrun  output  1  one-cycle pulse when a completed byte is dropped because the FIFO is full
fifo_level  output  $clog2(FIFO_DEPTH)+1  number of bytes held

Behaviour:
- Clocking and reset: one clock (wb_clk_i). Reset wb_rst_i is synchronous and active-high.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, fifo_level=0.
  - Synchroniser flops = 1, FSM = IDLE, bit counter = 0, shift register = 0.
- Input synchroniser: ser_rx passes through a 2-flop synchroniser; all sampling uses the synchronised value rxs.
- Baud counter: down-counter. When it reaches 0 in a sampling state, the sample is taken and the counter reloads with clk_div. A clk_div change mid-frame takes effect at the next reload.
- FSM states and transitions:
  - IDLE: when enable=1 and rxs=0, load counter with clk_div>>1 and go to START.
  - START: at counter 0, sample rxs.
    - rxs=1: false start (glitch); go to IDLE.
    - rxs=0: reload counter, bit index = 0, go to DATA.
  - DATA: at each counter 0, shift rxs in LSB-first. After the 8th bit, go to STOP.
  - STOP: at counter 0, sample rxs.
    - rxs=1: push the byte and go to IDLE.
    - rxs=0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. No start detection happens while in BREAK.
  - enable=0 in any state: next state is IDLE and the partial byte is discarded.
- FIFO push rules:
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overrun pulses in the cycle after the stop-bit sample.
- FIFO output: first-word-fall-through.
  - rx_valid = (level != 0); rx_data = head entry.
  - A pop occurs when rx_valid && rx_ready.
  - rx_data holds stable while rx_valid=1 and rx_ready=0.
- Latency: rx_valid for a byte entering an empty FIFO rises the cycle after the stop-bit sample cycle.
- Ordering: bytes are delivered in arrival order. Pointers wrap modulo FIFO_DEPTH.
- fifo_level update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Reset mid-frame: everything returns to the reset values above. If the line is low when reset releases, the block re-syncs via IDLE start detection.

Decomposition:
- Shared package sudoku_uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, STOP, BREAK).
  - DATA_BITS=8 constant.
  - Reset value constant for the synchroniser.
- Natural sub-module: sudoku_sync_fifo. It is a parameterised FWFT FIFO with push/pop, full/empty and level, reusable later by the TX path.

Test Plan:
- clk_div=15, send 0xA5 with rx_ready=1 -> rx_valid for exactly 1 cycle with rx_data=0xA5; frame_err=0, overrun=0.
- clk_div=15, rx_ready=0, send back-to-back 0x01..0x05 -> fifo_level reaches 4 and overrun pulses once after byte 5. Then raise rx_ready -> 0x01,0x02,0x03,0x04 drained in order, fifo_level returns to 0.
- Send 0x3C with stop bit driven 0, line held low 40 cycles, then high, then send 0x7E -> one frame_err pulse, 0x3C not pushed, no spurious start during the low period, 0x7E received.
- Line low for 4 cycles then high (clk_div=15) -> no byte, FSM back in IDLE, no error pulses.
- FIFO full with rx_ready=1 asserted in the same cycle as the 5th push -> pop and push both happen, no overrun, fifo_level stays 4.
- Assert wb_rst_i for 1 cycle during DATA bit 3 of a frame -> outputs return to reset values; a following 0x5A frame is received correctly.

Source files
------------

// File: rtl/sudoku_uart_pkg.sv
// Shared definitions for the sudoku accelerator UART receive path.
package sudoku_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int DATA_BITS = 8;

    // The serial line idles high, so the synchroniser resets to the idle level.
    localparam logic SYNC_RESET_VAL = 1'b1;

endpackage

// File: rtl/sudoku_sync_fifo.sv
// Parameterised first-word-fall-through FIFO with level reporting.
module sudoku_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/sudoku_uart_rx.sv
// 8N1 UART receiver feeding a FWFT byte FIFO, with framing and overrun pulses.
module sudoku_uart_rx
    import sudoku_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          clk_div,
    input  logic                          ser_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic [1:0]           sync_q, sync_d;
    rx_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rxs;
    logic                 sample;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign rxs       = sync_q[1];
    assign sample    = (cnt_q == '0);
    assign pop       = rx_valid && rx_ready;
    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // Start detection loads half a bit so every later sample lands mid-bit.
    always_comb begin
        sync_d      = {sync_q[0], ser_rx};
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        cnt_d   = clk_div >> 1;
                        state_d = ST_START;
                    end
                end
                ST_START, ST_DATA, ST_STOP: begin
                    if (!sample) begin
                        cnt_d = cnt_q - DIV_WIDTH'(1);
                    end else begin
                        cnt_d = clk_div;
                        if (state_q == ST_START) begin
                            bit_idx_d = '0;
                            state_d   = rxs ? ST_IDLE : ST_DATA;
                        end else if (state_q == ST_DATA) begin
                            shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
                            bit_idx_d = bit_idx_q + BIT_W'(1);
                            if (bit_idx_q == LAST_BIT) begin
                                state_d = ST_STOP;
                            end
                        end else if (rxs) begin
                            push    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        overrun_d = push && fifo_full && !pop;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q      <= {2{SYNC_RESET_VAL}};
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sudoku_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (wb_clk_i),
        .reset     (wb_rst_i),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .head_data (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule
